// File: rtl/proc_ctrl.sv
// proc_ctrl: sequencing controller for the simple bus-mux datapath.
// Steps each instruction {op, rx, ry} through one (load/move) or three
// (add/sub) control cycles. All datapath controls are decoded from the
// registered state and IR only, so start and instr never reach an output
// combinationally.
// Optional feature: define PROC_CTRL_PENDING_EN to add a one-deep pending
// instruction slot, which allows back-to-back issue with no IDLE gap.
module proc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] instr,
    output logic       ready,
    output logic       busy,
    output logic [1:0] mux_sel,
    output logic [1:0] rd_addr,
    output logic [3:0] r_load,
    output logic       a_load,
    output logic       g_load,
    output logic       add_sub,
    output logic       done
);
    localparam logic [1:0] IDLE_SEL = 2'b11;
    localparam logic [1:0] SEL_EXT  = 2'b00;
    localparam logic [1:0] SEL_REG  = 2'b01;
    localparam logic [1:0] SEL_G    = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

    state_t     state_q, state_d;
    logic [5:0] ir_q, ir_d;
    logic [1:0] op, rx, ry;
    logic       accept;

    assign op = ir_q[5:4];
    assign rx = ir_q[3:2];
    assign ry = ir_q[1:0];

`ifdef PROC_CTRL_PENDING_EN
    logic       pend_valid_q, pend_valid_d;
    logic [5:0] pend_ir_q, pend_ir_d;

    // A new instruction fits whenever the machine is idle or the slot is free
    assign ready = (state_q == S_IDLE) || !pend_valid_q;
`else
    assign ready = (state_q == S_IDLE);
`endif

    assign busy   = (state_q != S_IDLE);
    assign accept = start && ready;

    // Datapath control decode from registered state and IR
    always_comb begin
        mux_sel = IDLE_SEL;
        rd_addr = 2'b00;
        r_load  = 4'b0000;
        a_load  = 1'b0;
        g_load  = 1'b0;
        add_sub = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_T1: begin
                if (!op[1]) begin
                    // load / move finish in a single cycle
                    r_load = 4'b0001 << rx;
                    done   = 1'b1;
                    if (op[0]) begin
                        mux_sel = SEL_REG;
                        rd_addr = ry;
                    end else begin
                        mux_sel = SEL_EXT;
                    end
                end else begin
                    mux_sel = SEL_REG;
                    rd_addr = rx;
                    a_load  = 1'b1;
                end
            end
            S_T2: begin
                mux_sel = SEL_REG;
                rd_addr = ry;
                g_load  = 1'b1;
                add_sub = op[0];
            end
            S_T3: begin
                mux_sel = SEL_G;
                r_load  = 4'b0001 << rx;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state, IR capture and pending-slot bookkeeping
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
`ifdef PROC_CTRL_PENDING_EN
        pend_valid_d = pend_valid_q;
        pend_ir_d    = pend_ir_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ir_d    = instr;
                    state_d = S_T1;
                end
            end
            S_T1:    state_d = op[1] ? S_T2 : S_IDLE;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef PROC_CTRL_PENDING_EN
        if (done) begin
            // Chain straight into the next instruction, slot first
            if (pend_valid_q) begin
                ir_d         = pend_ir_q;
                state_d      = S_T1;
                pend_valid_d = 1'b0;
            end else if (accept) begin
                ir_d    = instr;
                state_d = S_T1;
            end
        end else if (busy && accept) begin
            pend_ir_d    = instr;
            pend_valid_d = 1'b1;
        end
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= 6'b0;
`ifdef PROC_CTRL_PENDING_EN
            pend_valid_q <= 1'b0;
            pend_ir_q    <= 6'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
`ifdef PROC_CTRL_PENDING_EN
            pend_valid_q <= pend_valid_d;
            pend_ir_q    <= pend_ir_d;
`endif
        end
    end
endmodule
